// File: rtl/seq_divider_pkg.sv
// Shared definitions for the iterative restoring divider.
package seq_divider_pkg;

   localparam int unsigned DIV_WIDTH = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/seq_divider_if.sv
// Start/busy/done request bus between the ALU issue logic and the divider.
interface seq_divider_if
   import seq_divider_pkg::*;
#(
   parameter int unsigned WIDTH = DIV_WIDTH
);

   logic             start;
   logic [WIDTH-1:0] dividend;
   logic [WIDTH-1:0] divisor;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] quotient;
   logic [WIDTH-1:0] remainder;
   logic             div_by_zero;

   modport master (
      output start, dividend, divisor,
      input  busy, done, quotient, remainder, div_by_zero
   );

   modport slave (
      input  start, dividend, divisor,
      output busy, done, quotient, remainder, div_by_zero
   );

endinterface

// File: rtl/seq_divider_lookahead_subtractor.sv
// N-bit subtractor a + ~b + 1 with every carry formed directly from generate/propagate terms.
module lookahead_subtractor #(
   parameter int unsigned N = 9
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   output logic [N-1:0] diff,
   output logic         borrow
);

   logic [N-1:0] g;
   logic [N-1:0] p;
   logic [N:0]   c;
   logic         cc;
   logic         prop;

   assign g = a & ~b;
   assign p = a ^ ~b;

   // c[i+1] = g[i] | p[i]g[i-1] | ... | p[i..0]cin, expanded rather than rippled
   always_comb begin
      c    = '0;
      cc   = 1'b0;
      prop = 1'b0;
      c[0] = 1'b1;
      for (int unsigned i = 0; i < N; i++) begin
         cc   = g[i];
         prop = p[i];
         for (int unsigned j = i; j > 0; j--) begin
            cc   = cc | (prop & g[j-1]);
            prop = prop & p[j-1];
         end
         c[i+1] = cc | (prop & c[0]);
      end
   end

   assign diff   = p ^ c[N-1:0];
   assign borrow = ~c[N];

endmodule

// File: rtl/seq_divider.sv
// Iterative unsigned restoring divider: one quotient bit per clock, start/busy/done handshake.
module seq_divider
   import seq_divider_pkg::*;
#(
   parameter int unsigned WIDTH = DIV_WIDTH
) (
   input  logic       clk,
   input  logic       rst_n,
   seq_divider_if.slave bus
);

   localparam int unsigned    CW         = $clog2(WIDTH);
   localparam logic [CW-1:0] COUNT_INIT = CW'(WIDTH - 1);

   state_t           state;
   state_t           state_next;
   logic [WIDTH:0]   r_reg;
   logic [WIDTH:0]   trial;
   logic [WIDTH:0]   diff;
   logic [WIDTH:0]   r_next;
   logic [WIDTH-1:0] q_reg;
   logic [WIDTH-1:0] q_next;
   logic [WIDTH-1:0] d_reg;
   logic [CW-1:0]    count;
   logic             borrow;
   logic             accept;
   logic             zero_div;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] quot_reg;
   logic [WIDTH-1:0] rem_reg;
   logic             dbz_reg;
   logic             r_top_unused;

   assign accept   = bus.start && ((state == ST_IDLE) || (state == ST_DONE));
   assign zero_div = (bus.divisor == '0);

   assign trial = {r_reg[WIDTH-1:0], q_reg[WIDTH-1]};

   lookahead_subtractor #(
      .N(WIDTH + 1)
   ) u_sub (
      .a      (trial),
      .b      ({1'b0, d_reg}),
      .diff   (diff),
      .borrow (borrow)
   );

   assign r_next = borrow ? trial : diff;
   assign q_next = {q_reg[WIDTH-2:0], ~borrow};

   // Partial remainder never exceeds the divisor, so its extra bit is never fed back.
   assign r_top_unused = r_reg[WIDTH];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      busy       = 1'b0;
      done       = 1'b0;
      case (state)
         ST_IDLE, ST_DONE: begin
            done = (state == ST_DONE);
            if (accept) begin
               state_next = zero_div ? ST_DONE : ST_CALC;
            end else begin
               state_next = ST_IDLE;
            end
         end
         ST_CALC: begin
            busy = 1'b1;
            if (count == '0) begin
               state_next = ST_DONE;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_reg    <= '0;
         q_reg    <= '0;
         d_reg    <= '0;
         count    <= '0;
         quot_reg <= '0;
         rem_reg  <= '0;
         dbz_reg  <= 1'b0;
      end else if (accept) begin
         if (zero_div) begin
            quot_reg <= '1;
            rem_reg  <= bus.dividend;
            dbz_reg  <= 1'b1;
         end else begin
            q_reg   <= bus.dividend;
            r_reg   <= '0;
            d_reg   <= bus.divisor;
            count   <= COUNT_INIT;
            dbz_reg <= 1'b0;
         end
      end else if (state == ST_CALC) begin
         r_reg <= r_next;
         q_reg <= q_next;
         count <= count - 1'b1;
         if (count == '0) begin
            quot_reg <= q_next;
            rem_reg  <= r_next[WIDTH-1:0];
         end
      end
   end

   assign bus.busy        = busy;
   assign bus.done        = done;
   assign bus.quotient    = quot_reg;
   assign bus.remainder   = rem_reg;
   assign bus.div_by_zero = dbz_reg;

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: directed handshake cases plus a random sweep.
module tb_seq_divider;
   import seq_divider_pkg::*;

   localparam int unsigned W = 8;

   typedef struct {
      int unsigned n;
      int unsigned d;
      int unsigned q;
      int unsigned r;
      bit          dbz;
      int unsigned due;
   } exp_t;

   logic        clk   = 1'b0;
   logic        rst_n = 1'b0;
   int unsigned cyc   = 0;
   int unsigned n_cmp = 0;
   int unsigned n_err = 0;
   exp_t        sb[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   seq_divider_if #(.WIDTH(W)) bus ();

   seq_divider #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   task automatic check(input string name, input longint act, input longint req);
      n_cmp++;
      if (act != req) begin
         n_err++;
         $display("FAIL %s: actual %0d required %0d (cycle %0d)", name, act, req, cyc);
      end
   endtask

   function automatic exp_t model(input int unsigned n, input int unsigned d, input int unsigned due);
      exp_t e;
      e.n   = n;
      e.d   = d;
      e.due = due;
      if (d == 0) begin
         e.q   = (1 << W) - 1;
         e.r   = n;
         e.dbz = 1'b1;
      end else begin
         e.q   = n / d;
         e.r   = n % d;
         e.dbz = 1'b0;
      end
      return e;
   endfunction

   always @(negedge clk) begin
      if (bus.done) begin
         if (sb.size() == 0) begin
            check("unexpected_done", bus.done, 0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("quotient", bus.quotient, e.q);
            check("remainder", bus.remainder, e.r);
            check("div_by_zero", bus.div_by_zero, e.dbz);
            check("done_cycle", cyc, e.due);
            if (!e.dbz) begin
               check("identity", bus.quotient * e.d + bus.remainder, e.n);
               check("rem_lt_div", (bus.remainder < e.d), 1);
            end
         end
      end
   end

   // Drive a request starting just after a negedge; returns one negedge later.
   task automatic issue(input int unsigned n, input int unsigned d, input bit expect_accept);
      bus.start    = 1'b1;
      bus.dividend = W'(n);
      bus.divisor  = W'(d);
      if (expect_accept) sb.push_back(model(n, d, cyc + ((d == 0) ? 1 : W + 1)));
      @(negedge clk);
      bus.start = 1'b0;
   endtask

   task automatic wait_drain(input int unsigned limit);
      int unsigned k = 0;
      while (sb.size() != 0 && k < limit) begin
         @(negedge clk);
         k++;
      end
      if (sb.size() != 0) begin
         check("drain_timeout", sb.size(), 0);
         sb.delete();
      end
      @(negedge clk);
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog: actual timeout required completion");
      $fatal(1);
   end

   initial begin
      int unsigned n;
      int unsigned d;
      bus.start    = 1'b0;
      bus.dividend = '0;
      bus.divisor  = '0;
      repeat (2) @(negedge clk);
      check("rst_busy", bus.busy, 0);
      check("rst_done", bus.done, 0);
      check("rst_quotient", bus.quotient, 0);
      check("rst_remainder", bus.remainder, 0);
      check("rst_dbz", bus.div_by_zero, 0);
      rst_n = 1'b1;
      @(negedge clk);

      // 100/7 with busy profile over cycles 1..W
      issue(100, 7, 1'b1);
      for (int unsigned k = 1; k <= W; k++) begin
         check("busy_calc", bus.busy, 1);
         check("done_calc", bus.done, 0);
         if (k < W) @(negedge clk);
      end
      @(negedge clk);
      check("busy_at_done", bus.busy, 0);
      wait_drain(20);
      repeat (3) @(negedge clk);
      check("hold_quotient", bus.quotient, 14);
      check("hold_remainder", bus.remainder, 2);

      issue(255, 1, 1'b1);
      wait_drain(20);
      issue(5, 9, 1'b1);
      wait_drain(20);

      // divide by zero, then a normal request clears the flag at accept
      issue(42, 0, 1'b1);
      check("dbz_busy", bus.busy, 0);
      wait_drain(20);
      issue(10, 3, 1'b1);
      check("dbz_clear_at_accept", bus.div_by_zero, 0);
      check("quotient_held", bus.quotient, 255);
      check("remainder_held", bus.remainder, 42);
      wait_drain(20);

      // start during CALC is ignored
      issue(200, 13, 1'b1);
      repeat (3) @(negedge clk);
      issue(9, 2, 1'b0);
      wait_drain(20);
      repeat (5) @(negedge clk);

      // asynchronous reset mid-division
      issue(200, 13, 1'b0);
      repeat (4) @(negedge clk);
      #1 rst_n = 1'b0;
      #1;
      check("arst_busy", bus.busy, 0);
      check("arst_done", bus.done, 0);
      check("arst_quotient", bus.quotient, 0);
      check("arst_remainder", bus.remainder, 0);
      check("arst_dbz", bus.div_by_zero, 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (15) @(negedge clk);
      check("post_reset_busy", bus.busy, 0);

      // back-to-back start in the done cycle
      issue(100, 7, 1'b1);
      repeat (W) @(negedge clk);
      issue(81, 9, 1'b1);
      check("b2b_busy", bus.busy, 1);
      wait_drain(30);

      for (int unsigned i = 0; i < 2000; i++) begin
         n = $urandom_range(0, 255);
         d = ($urandom_range(0, 15) == 0) ? 0 : $urandom_range(1, 255);
         issue(n, d, 1'b1);
         wait_drain(30);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
